// File: rtl/surfers_pkg.sv
// Shared types for the lane-runner collision checker: obstacle type
// encoding, obstacle word field positions, FSM states and small helpers.
package surfers_pkg;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        LOW   = 3'd1,
        HIGH  = 3'd2,
        MID   = 3'd3,
        TRAIN = 3'd4,
        RAMP  = 3'd5,
        CAR   = 3'd6
    } obs_type_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_REPORT  = 2'd2
    } cc_state_e;

    // obstacle word: {type[15:13], lane[12:11], depth[10:0]}
    localparam int OBS_TYPE_MSB  = 15;
    localparam int OBS_TYPE_LSB  = 13;
    localparam int OBS_LANE_MSB  = 12;
    localparam int OBS_LANE_LSB  = 11;
    localparam int OBS_DEPTH_MSB = 10;
    localparam int OBS_DEPTH_LSB = 0;

    localparam int TRAIN_HEIGHT_DEF = 64;

    // Clamp a 12-bit height into the 8-bit ground range.
    function automatic logic [7:0] sat8(input logic [11:0] v);
        return (v > 12'd255) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/obstacle_hit_eval.sv
// Combinational evaluation of one obstacle against the latched player state.
// Ports: en (obstacle presented while collecting), obstacle word, first_row,
// player lane/height/ducking in; hit flag and 8-bit ground candidate out.
module obstacle_hit_eval
    import surfers_pkg::*;
#(
    parameter int HIT_DEPTH    = 64,
    parameter int JUMP_CLEAR   = 32,
    parameter int TRAIN_HEIGHT = TRAIN_HEIGHT_DEF
) (
    input  logic        en,
    input  logic [15:0] obstacle,
    input  logic        first_row,
    input  logic [1:0]  lane,
    input  logic [7:0]  height,
    input  logic        ducking,
    output logic        hit,
    output logic [7:0]  gnd
);

    localparam logic [11:0] HD_W = 12'(HIT_DEPTH);
    localparam logic [8:0]  JC_W = 9'(JUMP_CLEAR);
    localparam logic [11:0] TH_W = 12'(TRAIN_HEIGHT);

    obs_type_e   o_type;
    logic [1:0]  o_lane;
    logic [10:0] o_depth;
    logic [11:0] d12;
    logic [11:0] dmin;
    logic        relevant;
    logic        h_clear;
    logic        h_over_train;

    assign o_type  = obs_type_e'(obstacle[OBS_TYPE_MSB:OBS_TYPE_LSB]);
    assign o_lane  = obstacle[OBS_LANE_MSB:OBS_LANE_LSB];
    assign o_depth = obstacle[OBS_DEPTH_MSB:OBS_DEPTH_LSB];
    assign d12     = {1'b0, o_depth};
    assign dmin    = (d12 < TH_W) ? d12 : TH_W;

    // lane 3 is not a real lane, so it never matches
    assign relevant = en && (o_lane == lane) && (o_lane != 2'd3)
                      && (d12 < HD_W);

    assign h_clear      = ({1'b0, height} >= JC_W);
    assign h_over_train = ({4'b0, height} >= TH_W);

    always_comb begin
        hit = 1'b0;
        gnd = 8'd0;
        if (relevant) begin
            unique case (o_type)
                LOW:   hit = ~h_clear;
                HIGH:  hit = ~ducking;
                MID:   hit = ~(ducking | h_clear);
                TRAIN: begin
                    // only the train's front face can be run into
                    if (first_row && !h_over_train) hit = 1'b1;
                    else                            gnd = sat8(TH_W);
                end
                RAMP:  gnd = sat8(TH_W - dmin);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/collision_checker.sv
// Per-frame collision checker: latches player state on activate, folds
// obstacles into a hit flag and max ground height, reports once per frame.
// Ports: clk, rst (sync, active-high), activate, player_*, obs_* in;
// busy, result_valid, collision, ground_height, timeout out.
// Optional macro INVULN_COLLISION_EN adds a post-hit grace counter.
module collision_checker
    import surfers_pkg::*;
#(
    parameter int HIT_DEPTH      = 64,
    parameter int JUMP_CLEAR     = 32,
    parameter int TRAIN_HEIGHT   = TRAIN_HEIGHT_DEF,
    parameter int TIMEOUT_CYCLES = 65535
`ifdef INVULN_COLLISION_EN
    ,
    parameter int INVULN_FRAMES  = 60
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        activate,
    input  logic [1:0]  player_lane,
    input  logic [7:0]  player_height,
    input  logic        player_ducking,
    input  logic        obs_valid,
    input  logic        obs_first_row,
    input  logic [15:0] obstacle,
    input  logic        obs_done,
    output logic        busy,
    output logic        result_valid,
    output logic        collision,
    output logic [7:0]  ground_height,
    output logic        timeout
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    cc_state_e   state_q, state_d;
    logic [1:0]  lane_q, lane_d;
    logic [7:0]  height_q, height_d;
    logic        duck_q, duck_d;
    logic        hit_q, hit_d;
    logic [7:0]  gnd_q, gnd_d;
    logic [15:0] cnt_q, cnt_d;
    logic        rv_q, rv_d;
    logic        col_q, col_d;
    logic [7:0]  ground_q, ground_d;
    logic        to_q, to_d;
`ifdef INVULN_COLLISION_EN
    localparam logic [15:0] GRACE_INIT = 16'(INVULN_FRAMES);
    logic [15:0] grace_q, grace_d;
`endif

    logic        o_hit;
    logic [7:0]  o_gnd;

    obstacle_hit_eval #(
        .HIT_DEPTH    (HIT_DEPTH),
        .JUMP_CLEAR   (JUMP_CLEAR),
        .TRAIN_HEIGHT (TRAIN_HEIGHT)
    ) u_eval (
        .en        (obs_valid && (state_q == S_COLLECT)),
        .obstacle  (obstacle),
        .first_row (obs_first_row),
        .lane      (lane_q),
        .height    (height_q),
        .ducking   (duck_q),
        .hit       (o_hit),
        .gnd       (o_gnd)
    );

    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        height_d = height_q;
        duck_d   = duck_q;
        hit_d    = hit_q;
        gnd_d    = gnd_q;
        cnt_d    = cnt_q;
        rv_d     = 1'b0;
        col_d    = col_q;
        ground_d = ground_q;
        to_d     = to_q;
`ifdef INVULN_COLLISION_EN
        grace_d  = grace_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (activate) begin
                    state_d  = S_COLLECT;
                    lane_d   = player_lane;
                    height_d = player_height;
                    duck_d   = player_ducking;
                    hit_d    = 1'b0;
                    gnd_d    = 8'd0;
                    cnt_d    = 16'd0;
                end
            end
            S_COLLECT: begin
                hit_d = hit_q | o_hit;
                gnd_d = (o_gnd > gnd_q) ? o_gnd : gnd_q;
                cnt_d = cnt_q + 16'd1;
                // the obstacle of this cycle is folded in before reporting
                if (obs_done || (cnt_q == TO_LAST)) begin
                    state_d  = S_REPORT;
                    rv_d     = 1'b1;
                    to_d     = ~obs_done;
                    ground_d = gnd_d;
`ifdef INVULN_COLLISION_EN
                    if (grace_q != 16'd0) begin
                        col_d   = 1'b0;
                        grace_d = grace_q - 16'd1;
                    end else begin
                        col_d = hit_d;
                        if (hit_d) grace_d = GRACE_INIT;
                    end
`else
                    col_d = hit_d;
`endif
                end
            end
            S_REPORT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            lane_q   <= 2'd0;
            height_q <= 8'd0;
            duck_q   <= 1'b0;
            hit_q    <= 1'b0;
            gnd_q    <= 8'd0;
            cnt_q    <= 16'd0;
            rv_q     <= 1'b0;
            col_q    <= 1'b0;
            ground_q <= 8'd0;
            to_q     <= 1'b0;
`ifdef INVULN_COLLISION_EN
            grace_q  <= 16'd0;
`endif
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            height_q <= height_d;
            duck_q   <= duck_d;
            hit_q    <= hit_d;
            gnd_q    <= gnd_d;
            cnt_q    <= cnt_d;
            rv_q     <= rv_d;
            col_q    <= col_d;
            ground_q <= ground_d;
            to_q     <= to_d;
`ifdef INVULN_COLLISION_EN
            grace_q  <= grace_d;
`endif
        end
    end

    assign busy          = (state_q == S_COLLECT) || (state_q == S_REPORT);
    assign result_valid  = rv_q;
    assign collision     = col_q;
    assign ground_height = ground_q;
    assign timeout       = to_q;

endmodule

// File: tb/tb_collision_checker.sv
// Directed self-checking bench for collision_checker.
// Runs with TIMEOUT_CYCLES=100 (and INVULN_FRAMES=2 when enabled).
module tb_collision_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        activate = 1'b0;
    logic [1:0]  player_lane = 2'd0;
    logic [7:0]  player_height = 8'd0;
    logic        player_ducking = 1'b0;
    logic        obs_valid = 1'b0;
    logic        obs_first_row = 1'b0;
    logic [15:0] obstacle = 16'd0;
    logic        obs_done = 1'b0;
    logic        busy;
    logic        result_valid;
    logic        collision;
    logic [7:0]  ground_height;
    logic        timeout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    collision_checker #(
        .HIT_DEPTH      (64),
        .JUMP_CLEAR     (32),
        .TRAIN_HEIGHT   (64),
        .TIMEOUT_CYCLES (100)
`ifdef INVULN_COLLISION_EN
        ,
        .INVULN_FRAMES  (2)
`endif
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .activate       (activate),
        .player_lane    (player_lane),
        .player_height  (player_height),
        .player_ducking (player_ducking),
        .obs_valid      (obs_valid),
        .obs_first_row  (obs_first_row),
        .obstacle       (obstacle),
        .obs_done       (obs_done),
        .busy           (busy),
        .result_valid   (result_valid),
        .collision      (collision),
        .ground_height  (ground_height),
        .timeout        (timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic start_frame(input logic [1:0] l, input logic [7:0] h,
                               input logic d);
        player_lane    = l;
        player_height  = h;
        player_ducking = d;
        activate       = 1'b1;
        tick();
        activate       = 1'b0;
    endtask

    task automatic send_obs(input logic [2:0] t, input logic [1:0] l,
                            input logic [10:0] dep, input logic fr,
                            input logic done);
        obs_valid     = 1'b1;
        obstacle      = {t, l, dep};
        obs_first_row = fr;
        obs_done      = done;
        tick();
        obs_valid     = 1'b0;
        obs_first_row = 1'b0;
        obs_done      = 1'b0;
    endtask

    task automatic send_done();
        obs_done = 1'b1;
        tick();
        obs_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        checks++;
        if (result_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rv: got %b want 0", result_valid);
        end
        checks++;
        if (collision !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got col=%b to=%b want 0 0",
                     collision, timeout);
        end
        checks++;
        if (ground_height !== 8'd0) begin
            errors++;
            $display("FAIL reset_ground: got %0d want 0", ground_height);
        end
    endtask

    task automatic test_low();
        do_reset();
        start_frame(2'd1, 8'd0, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL low_busy: got %b want 1", busy);
        end
        send_obs(3'b001, 2'd1, 11'd40, 1'b0, 1'b0);
        checks++;
        if (result_valid !== 1'b0) begin
            errors++;
            $display("FAIL low_early_rv: got %b want 0", result_valid);
        end
        send_done();
        checks++;
        if (result_valid !== 1'b1) begin
            errors++;
            $display("FAIL low_rv: got %b want 1", result_valid);
        end
        checks++;
        if (collision !== 1'b1 || ground_height !== 8'd0
            || timeout !== 1'b0) begin
            errors++;
            $display("FAIL low_result: got col=%b gnd=%0d to=%b want 1 0 0",
                     collision, ground_height, timeout);
        end
        tick();
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL low_pulse_end: got rv=%b busy=%b want 0 0",
                     result_valid, busy);
        end
        tick();
        checks++;
        if (collision !== 1'b1) begin
            errors++;
            $display("FAIL low_hold: got %b want 1", collision);
        end
    endtask

    task automatic test_latch_clear();
        do_reset();
        start_frame(2'd1, 8'd40, 1'b0);
        // live inputs change; the latched copy must be used
        player_height = 8'd0;
        player_lane   = 2'd2;
        send_obs(3'b001, 2'd1, 11'd40, 1'b0, 1'b0);
        send_obs(3'b010, 2'd2, 11'd10, 1'b0, 1'b0);
        send_done();
        checks++;
        if (result_valid !== 1'b1 || collision !== 1'b0) begin
            errors++;
            $display("FAIL clear_jump: got rv=%b col=%b want 1 0",
                     result_valid, collision);
        end
        tick();
    endtask

    task automatic test_train();
        do_reset();
        start_frame(2'd0, 8'd0, 1'b0);
        send_obs(3'b100, 2'd0, 11'd20, 1'b1, 1'b0);
        send_done();
        checks++;
        if (result_valid !== 1'b1 || collision !== 1'b1
            || ground_height !== 8'd0) begin
            errors++;
            $display("FAIL train_front: got rv=%b col=%b gnd=%0d want 1 1 0",
                     result_valid, collision, ground_height);
        end
        tick();
        start_frame(2'd0, 8'd64, 1'b0);
        send_obs(3'b100, 2'd0, 11'd20, 1'b0, 1'b0);
        send_done();
        checks++;
        if (result_valid !== 1'b1 || collision !== 1'b0
            || ground_height !== 8'd64) begin
            errors++;
            $display("FAIL train_roof: got rv=%b col=%b gnd=%0d want 1 0 64",
                     result_valid, collision, ground_height);
        end
        tick();
        start_frame(2'd0, 8'd64, 1'b0);
        send_obs(3'b100, 2'd0, 11'd20, 1'b1, 1'b0);
        send_done();
        checks++;
        if (collision !== 1'b0 || ground_height !== 8'd64) begin
            errors++;
            $display("FAIL train_over: got col=%b gnd=%0d want 0 64",
                     collision, ground_height);
        end
        tick();
    endtask

    task automatic test_ramp();
        do_reset();
        start_frame(2'd2, 8'd0, 1'b0);
        send_obs(3'b100, 2'd2, 11'd64, 1'b0, 1'b0);
        send_obs(3'b110, 2'd2, 11'd5, 1'b1, 1'b0);
        send_obs(3'b101, 2'd2, 11'd40, 1'b0, 1'b0);
        send_obs(3'b101, 2'd2, 11'd16, 1'b0, 1'b1);
        checks++;
        if (result_valid !== 1'b1) begin
            errors++;
            $display("FAIL ramp_rv: got %b want 1", result_valid);
        end
        checks++;
        if (ground_height !== 8'd48 || collision !== 1'b0) begin
            errors++;
            $display("FAIL ramp_ground: got gnd=%0d col=%b want 48 0",
                     ground_height, collision);
        end
        tick();
    endtask

    task automatic test_duck();
        do_reset();
        start_frame(2'd0, 8'd0, 1'b1);
        send_obs(3'b010, 2'd0, 11'd5, 1'b0, 1'b0);
        send_obs(3'b011, 2'd0, 11'd5, 1'b0, 1'b1);
        checks++;
        if (result_valid !== 1'b1 || collision !== 1'b0) begin
            errors++;
            $display("FAIL duck_under: got rv=%b col=%b want 1 0",
                     result_valid, collision);
        end
        tick();
        start_frame(2'd0, 8'd40, 1'b0);
        send_obs(3'b011, 2'd0, 11'd5, 1'b0, 1'b1);
        checks++;
        if (collision !== 1'b0) begin
            errors++;
            $display("FAIL mid_jump: got %b want 0", collision);
        end
        tick();
        start_frame(2'd0, 8'd31, 1'b0);
        send_obs(3'b011, 2'd0, 11'd63, 1'b0, 1'b1);
        checks++;
        if (collision !== 1'b1) begin
            errors++;
            $display("FAIL mid_short: got %b want 1", collision);
        end
        tick();
        do_reset();
        start_frame(2'd0, 8'd0, 1'b0);
        send_obs(3'b001, 2'd0, 11'd64, 1'b0, 1'b1);
        checks++;
        if (result_valid !== 1'b1 || collision !== 1'b0) begin
            errors++;
            $display("FAIL depth_edge: got rv=%b col=%b want 1 0",
                     result_valid, collision);
        end
        tick();
    endtask

    task automatic test_ignore();
        do_reset();
        send_obs(3'b001, 2'd0, 11'd1, 1'b0, 1'b1);
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore: got rv=%b busy=%b want 0 0",
                     result_valid, busy);
        end
        start_frame(2'd1, 8'd0, 1'b0);
        send_obs(3'b001, 2'd1, 11'd10, 1'b0, 1'b0);
        // re-activate mid-frame must not clear the hit
        start_frame(2'd0, 8'd100, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reactivate_busy: got %b want 1", busy);
        end
        send_done();
        checks++;
        if (result_valid !== 1'b1 || collision !== 1'b1) begin
            errors++;
            $display("FAIL reactivate: got rv=%b col=%b want 1 1",
                     result_valid, collision);
        end
        tick();
    endtask

    task automatic test_timeout();
        int  n;
        logic seen;
        do_reset();
        start_frame(2'd0, 8'd0, 1'b0);
        send_obs(3'b001, 2'd0, 11'd5, 1'b0, 1'b0);
        n = 1;
        while (result_valid !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (n != 100) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles want 100", n);
        end
        checks++;
        if (timeout !== 1'b1 || collision !== 1'b1) begin
            errors++;
            $display("FAIL timeout_flags: got to=%b col=%b want 1 1",
                     timeout, collision);
        end
        tick();
        start_frame(2'd0, 8'd0, 1'b0);
        repeat (49) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || collision !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: got busy=%b col=%b to=%b want 0 0 0",
                     busy, collision, timeout);
        end
        seen = 1'b0;
        for (int i = 0; i < 150; i++) begin
            if (result_valid === 1'b1) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midrst_pulse: got rv pulse=%b want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_col [4];
`ifdef INVULN_COLLISION_EN
        exp_col = '{1'b1, 1'b0, 1'b0, 1'b1};
`else
        exp_col = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        do_reset();
        for (int f = 0; f < 4; f++) begin
            start_frame(2'd1, 8'd0, 1'b0);
            send_obs(3'b001, 2'd1, 11'd1, 1'b0, 1'b1);
            checks++;
            if (result_valid !== 1'b1 || collision !== exp_col[f]) begin
                errors++;
                $display("FAIL b2b_frame%0d: got rv=%b col=%b want 1 %b",
                         f, result_valid, collision, exp_col[f]);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_low();
        test_latch_clear();
        test_train();
        test_ramp();
        test_duck();
        test_ignore();
        test_timeout();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/collision_checker.md
COLLISION_CHECKER -- requirements
Module: collision_checker

Interface
REQ-001 Param HIT_DEPTH, 64: obstacles with depth < HIT_DEPTH occupy the player's slot.
REQ-002 Param JUMP_CLEAR, 32: minimum player_height that clears low/middle barriers.
REQ-003 Param TRAIN_HEIGHT, 64: train roof height in world units.
REQ-004 Param TIMEOUT_CYCLES, 65535: maximum COLLECT duration before forced report.
REQ-005 Param INVULN_FRAMES, 60: post-hit grace frames (INVULN_COLLISION_EN only).
REQ-006 clk  in  1  sole clock; rst  in  1  synchronous, active-high reset.
REQ-007 activate  in  1  one-cycle frame-start pulse.
REQ-008 player_lane  in  2 (0..2); player_height  in  8; player_ducking  in  1.
REQ-009 obs_valid  in  1; obs_first_row  in  1; obstacle  in  16  {type[15:13], lane[12:11], depth[10:0]}; obs_done  in  1.
REQ-010 busy  out  1  high in COLLECT and REPORT.
REQ-011 result_valid  out  1  one-cycle pulse; collision  out  1; ground_height  out  8; timeout  out  1; all valid while result_valid is high.

Function
REQ-012 States IDLE, COLLECT, REPORT; IDLE->COLLECT on activate; COLLECT->REPORT on obs_done or timeout; REPORT->IDLE after exactly one cycle.
REQ-013 On activate, player_lane/height/ducking are latched; changes during COLLECT are ignored.
REQ-014 Obstacle is relevant iff obs_valid, state==COLLECT, lane==latched lane, depth < HIT_DEPTH.
REQ-015 Type 001: hit if height < JUMP_CLEAR.
REQ-016 Type 010: hit unless ducking.
REQ-017 Type 011: hit unless ducking or height >= JUMP_CLEAR.
REQ-018 Type 100: with obs_first_row=1 and height < TRAIN_HEIGHT -> hit; otherwise ground candidate TRAIN_HEIGHT.
REQ-019 Type 101: never a hit; ground candidate TRAIN_HEIGHT - min(depth, TRAIN_HEIGHT), computed at 12 bits, saturating at 0.
REQ-020 Types 000, 110, 111 and lane 3 are ignored.
REQ-021 Hit flag ORs; ground accumulator takes the max of candidates; both clear to 0 on activate.
REQ-022 obs_valid with obs_done in the same cycle: the obstacle is accumulated, then REPORT is entered.
REQ-023 activate during COLLECT/REPORT and obs_valid/obs_done in IDLE are ignored.
REQ-024 Cycle counter starts at 0 on activate; reaching TIMEOUT_CYCLES without obs_done -> REPORT with timeout=1, accumulated results preserved.
REQ-025 Latency: result_valid is asserted exactly 1 cycle after the cycle obs_done is sampled.
REQ-026 Outputs are registered; collision, ground_height and timeout hold until the next REPORT.

Reset
REQ-027 rst forces IDLE; busy, result_valid, collision, timeout = 0; ground_height = 0; accumulators, counter and grace counter = 0.
REQ-028 rst mid-COLLECT abandons the frame with no result_valid pulse.

Configuration
REQ-029 Macro INVULN_COLLISION_EN defined: a reported collision loads grace=INVULN_FRAMES; while grace != 0, collision is forced to 0 and grace decrements once per REPORT.
REQ-030 Macro INVULN_COLLISION_EN undefined: no grace counter; every accumulated hit is reported.

Structure
REQ-031 Package surfers_pkg holds the obstacle type enum (NONE, LOW, HIGH, MID, TRAIN, RAMP, CAR), obstacle field bit positions, and TRAIN_HEIGHT default.
REQ-032 Sub-module obstacle_hit_eval: combinational, one obstacle plus latched player state in -> hit, ground candidate out; FSM and accumulators stay in collision_checker.

Verification
REQ-033 lane 1, height 0; obstacle {001,1,40} then done -> result_valid, collision=1, ground_height=0.
REQ-034 lane 1, height 40; {001,1,40} and {010,2,10} -> collision=0.
REQ-035 lane 0, height 0; first_row=1 {100,0,20} -> collision=1; repeated with height 64, first_row=0 -> collision=0, ground_height=64.
REQ-036 lane 2; ramp {101,2,16} plus ramp {101,2,40} -> ground_height=48; valid+done same cycle counted.
REQ-037 activate, no obs_done, TIMEOUT_CYCLES=100 -> result_valid at cycle 101 with timeout=1; rst at cycle 50 of a new frame -> no result_valid pulse.
REQ-038 INVULN_COLLISION_EN, INVULN_FRAMES=2: three consecutive hit frames -> collision 1,0,0, fourth hit frame -> 1.
